// File: rtl/ca_pkt_if.sv
// Command/address packet bus between the controller-side packet source and the
// DRAM-side decoder: sampled CS_n/CA inputs plus the decoded command outputs.
interface ca_pkt_if #(
  parameter int CA_W  = 14,
  parameter int ROW_W = 16,
  parameter int COL_W = 10
);
  logic             CS_n;
  logic [CA_W-1:0]  CA;
  logic             cmd_valid;
  logic [3:0]       cmd;
  logic [2:0]       bg;
  logic             ba;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [15:0]      bank_open;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    output CS_n, CA,
    input  cmd_valid, cmd, bg, ba, row, col, bank_open, err, err_code
  );

  modport slave (
    input  CS_n, CA,
    output cmd_valid, cmd, bg, ba, row, col, bank_open, err, err_code
  );
endinterface

// File: rtl/ca_pkt_decoder.sv
// Two-UI CA packet receiver: reassembles UI0/UI1, decodes ACT/WRA/RDA and tracks
// per-bank open state. Optional UI1 fixed-bit checking under `CA_FIXED_CHK_EN.
module ca_pkt_decoder #(
  parameter int CA_W  = 14,
  parameter int ROW_W = 16,
  parameter int COL_W = 10
) (
  input logic     clk,
  input logic     rst_n,
  ca_pkt_if.slave bus
);
  typedef enum logic {S_UI0, S_UI1} state_t;

  localparam logic [3:0] C_IDLE = 4'd0;
  localparam logic [3:0] C_ACT  = 4'd8;
  localparam logic [3:0] C_WRA  = 4'd5;
  localparam logic [3:0] C_RDA  = 4'd12;

  state_t           r_state;
  logic [CA_W-1:0]  r_ui0;
  logic             r_cmd_valid;
  logic [3:0]       r_cmd;
  logic [2:0]       r_bg;
  logic             r_ba;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [15:0]      r_bank_open;
  logic             r_err;
  logic [1:0]       r_err_code;

  logic       w_is_act, w_is_wra, w_is_rda, w_fix_ok;
  logic [3:0] w_bidx;
  logic       w_unused;

  assign w_is_act = (r_ui0[1:0] == 2'b00);
  assign w_is_wra = (r_ui0[5:0] == 6'b001101);
  assign w_is_rda = (r_ui0[5:0] == 6'b011101);
  assign w_bidx   = {r_ui0[10:8], r_ui0[6]};

`ifdef CA_FIXED_CHK_EN
  always_comb begin
    w_fix_ok = 1'b1;
    if (w_is_act)      w_fix_ok = (bus.CA[13:12] == 2'b00);
    else if (w_is_wra) w_fix_ok = bus.CA[0] & bus.CA[9] & bus.CA[12] & ~bus.CA[13];
    else if (w_is_rda) w_fix_ok = bus.CA[9] & bus.CA[11] & bus.CA[12] & ~bus.CA[13];
  end
`else
  assign w_fix_ok = 1'b1;
`endif

  // UI bits that carry no field in this packet format
  assign w_unused = ^{bus.CA[13:12], r_ui0[13:11], r_ui0[7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_UI0;
      r_ui0       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= C_IDLE;
      r_bg        <= '0;
      r_ba        <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_bank_open <= '0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= C_IDLE;
      r_err       <= 1'b0;
      case (r_state)
        S_UI0: begin
          if (!bus.CS_n) begin
            r_ui0   <= bus.CA;
            r_state <= S_UI1;
          end
        end
        S_UI1: begin
          if (!bus.CS_n) begin
            // A new UI0 arrived before UI1: drop the pending packet, restart on it
            r_err      <= 1'b1;
            r_err_code <= 2'd2;
            r_ui0      <= bus.CA;
          end else begin
            r_state <= S_UI0;
            if (!(w_is_act || w_is_wra || w_is_rda) || !w_fix_ok) begin
              r_err      <= 1'b1;
              r_err_code <= 2'd1;
            end else begin
              r_cmd_valid <= 1'b1;
              r_bg        <= r_ui0[10:8];
              r_ba        <= r_ui0[6];
              if (w_is_act) begin
                r_cmd               <= C_ACT;
                r_row               <= {bus.CA[11:0], r_ui0[5:2]};
                r_col               <= '0;
                r_bank_open[w_bidx] <= 1'b1;
                if (r_bank_open[w_bidx]) begin
                  r_err      <= 1'b1;
                  r_err_code <= 2'd3;
                end
              end else begin
                r_cmd               <= w_is_wra ? C_WRA : C_RDA;
                r_row               <= '0;
                r_col               <= w_is_wra ? {bus.CA[7:1], 3'b000} : {bus.CA[7:0], 2'b00};
                r_bank_open[w_bidx] <= 1'b0;
                if (!r_bank_open[w_bidx]) begin
                  r_err      <= 1'b1;
                  r_err_code <= 2'd3;
                end
              end
            end
          end
        end
        default: r_state <= S_UI0;
      endcase
    end
  end

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd       = r_cmd;
  assign bus.bg        = r_bg;
  assign bus.ba        = r_ba;
  assign bus.row       = r_row;
  assign bus.col       = r_col;
  assign bus.bank_open = r_bank_open;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;
endmodule
